// File: rtl/lsb_stego_engine_if.sv
// Stream bundle for the LSB stego engine: image bytes in/out, plaintext in, recovered text out.
// The engine sits on the slave side; the producer/consumer environment uses master.
interface lsb_stego_engine_if #(
  parameter int PIX_W = 8,
  parameter int TXT_W = 4
) ();
  logic             pix_in_valid;
  logic             pix_in_ready;
  logic [PIX_W-1:0] pix_in_data;
  logic             txt_in_valid;
  logic             txt_in_ready;
  logic [TXT_W-1:0] txt_in_data;
  logic             pix_out_valid;
  logic             pix_out_ready;
  logic [PIX_W-1:0] pix_out_data;
  logic             txt_out_valid;
  logic [TXT_W-1:0] txt_out_data;

  modport master (
    output pix_in_valid, pix_in_data, txt_in_valid, txt_in_data, pix_out_ready,
    input  pix_in_ready, txt_in_ready, pix_out_valid, pix_out_data, txt_out_valid, txt_out_data
  );

  modport slave (
    input  pix_in_valid, pix_in_data, txt_in_valid, txt_in_data, pix_out_ready,
    output pix_in_ready, txt_in_ready, pix_out_valid, pix_out_data, txt_out_valid, txt_out_data
  );
endinterface

// File: rtl/lsb_stego_engine.sv
// Streaming LSB steganography engine: EMBED XOR-encrypts text symbols with a stored key and spreads
// them over image-byte LSBs; EXTRACT gathers those LSBs back and decrypts them.
module lsb_stego_engine #(
  parameter  int PIX_W     = 8,
  parameter  int TXT_W     = 4,
  parameter  int LSB_N     = 1,
  parameter  int KEY_DEPTH = 208,
  parameter  int CNT_W     = 16,
  localparam int KA_W      = (KEY_DEPTH > 1) ? $clog2(KEY_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] msg_len_i,
  input  logic [CNT_W-1:0] pix_count_i,
  input  logic             key_we_i,
  input  logic [KA_W-1:0]  key_addr_i,
  input  logic [TXT_W-1:0] key_data_i,
  lsb_stego_engine_if.slave bus,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_trunc_o
);
  localparam int CHUNKS = TXT_W / LSB_N;
  localparam int CH_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int PROD_W = CNT_W + CH_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [TXT_W-1:0] key_mem [KEY_DEPTH];
  logic [TXT_W-1:0] key_rd_q;

  logic [1:0]       state_q, state_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] msg_len_q, msg_len_d, pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] acc_q, acc_d, sym_q, sym_d;
  logic [CH_W-1:0]  chunk_q, chunk_d;
  logic [KA_W-1:0]  key_idx_q, key_idx_d;
  logic             buf_full_q, buf_full_d;
  logic [TXT_W-1:0] buf_q, buf_d, asm_q, asm_d;
  logic             pov_q, pov_d, tov_q, tov_d;
  logic [PIX_W-1:0] pod_q, pod_d;
  logic [TXT_W-1:0] tod_q, tod_d;
  logic             done_q, done_d, err_q, err_d;

  logic             sym_active, last_chunk, text_ok, out_free, in_fire, txt_fire;
  logic [TXT_W-1:0] cipher, asm_next;
  logic [LSB_N-1:0] chunk_sel [CHUNKS];
  logic [PIX_W-1:0] embed_byte;

  assign sym_active = (sym_q < msg_len_q);
  assign last_chunk = (chunk_q == CH_W'(CHUNKS - 1));
  assign text_ok    = mode_q || !sym_active || buf_full_q;
  assign out_free   = !pov_q || bus.pix_out_ready;
  assign in_fire    = bus.pix_in_valid && bus.pix_in_ready;
  assign txt_fire   = bus.txt_in_valid && bus.txt_in_ready;
  assign cipher     = buf_q ^ key_rd_q;

  // Chunk c of a symbol occupies bits [c*LSB_N +: LSB_N]; chunk 0 travels first.
  for (genvar gi = 0; gi < CHUNKS; gi++) begin : g_chunk
    assign chunk_sel[gi] = cipher[gi*LSB_N +: LSB_N];
    assign asm_next[gi*LSB_N +: LSB_N] = (chunk_q == CH_W'(gi)) ?
                                         bus.pix_in_data[LSB_N-1:0] : asm_q[gi*LSB_N +: LSB_N];
  end

  assign embed_byte = {bus.pix_in_data[PIX_W-1:LSB_N], chunk_sel[chunk_q]};

  assign bus.pix_in_ready  = (state_q == S_RUN) && out_free && text_ok;
  assign bus.txt_in_ready  = (state_q == S_RUN) && !buf_full_q && sym_active;
  assign bus.pix_out_valid = pov_q;
  assign bus.pix_out_data  = pod_q;
  assign bus.txt_out_valid = tov_q;
  assign bus.txt_out_data  = tod_q;
  assign busy_o            = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o            = done_q;
  assign err_trunc_o       = err_q;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    msg_len_d  = msg_len_q;
    pix_cnt_d  = pix_cnt_q;
    acc_d      = acc_q;
    sym_d      = sym_q;
    chunk_d    = chunk_q;
    key_idx_d  = key_idx_q;
    buf_full_d = buf_full_q;
    buf_d      = buf_q;
    asm_d      = asm_q;
    pov_d      = pov_q;
    pod_d      = pod_q;
    tov_d      = 1'b0;
    tod_d      = tod_q;
    done_d     = 1'b0;
    err_d      = err_q;

    if (pov_q && bus.pix_out_ready) pov_d = 1'b0;
    if (txt_fire) begin
      buf_d      = bus.txt_in_data;
      buf_full_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d     = mode_i;
          msg_len_d  = msg_len_i;
          pix_cnt_d  = pix_count_i;
          acc_d      = '0;
          sym_d      = '0;
          chunk_d    = '0;
          key_idx_d  = '0;
          buf_full_d = 1'b0;
          asm_d      = '0;
          err_d      = (PROD_W'(msg_len_i) * PROD_W'(CHUNKS)) > PROD_W'(pix_count_i);
          state_d    = (pix_count_i == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (in_fire) begin
          pov_d = 1'b1;
          pod_d = bus.pix_in_data;
          acc_d = acc_q + CNT_W'(1);
          if ((acc_q + CNT_W'(1)) == pix_cnt_q) state_d = S_DRAIN;
          if (sym_active) begin
            if (!mode_q) pod_d = embed_byte;
            else         asm_d = asm_next;
            if (last_chunk) begin
              chunk_d   = '0;
              sym_d     = sym_q + CNT_W'(1);
              key_idx_d = (key_idx_q == KA_W'(KEY_DEPTH - 1)) ? '0 : key_idx_q + KA_W'(1);
              if (!mode_q) begin
                buf_full_d = 1'b0;
              end else begin
                tov_d = 1'b1;
                tod_d = asm_next ^ key_rd_q;
              end
            end else begin
              chunk_d = chunk_q + CH_W'(1);
            end
          end
        end
      end
      S_DRAIN: begin
        if (out_free) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Key RAM survives reset; the read port prefetches the key for the next symbol index.
  always_ff @(posedge clk) begin
    if (reset && (state_q == S_IDLE) && key_we_i) key_mem[key_addr_i] <= key_data_i;
    key_rd_q <= key_mem[key_idx_d];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      msg_len_q  <= '0;
      pix_cnt_q  <= '0;
      acc_q      <= '0;
      sym_q      <= '0;
      chunk_q    <= '0;
      key_idx_q  <= '0;
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      asm_q      <= '0;
      pov_q      <= 1'b0;
      pod_q      <= '0;
      tov_q      <= 1'b0;
      tod_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      msg_len_q  <= msg_len_d;
      pix_cnt_q  <= pix_cnt_d;
      acc_q      <= acc_d;
      sym_q      <= sym_d;
      chunk_q    <= chunk_d;
      key_idx_q  <= key_idx_d;
      buf_full_q <= buf_full_d;
      buf_q      <= buf_d;
      asm_q      <= asm_d;
      pov_q      <= pov_d;
      pod_q      <= pod_d;
      tov_q      <= tov_d;
      tod_q      <= tod_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end
endmodule
